// File: rtl/fetch_pkg.sv
// Shared constants for the dtcore32 fetch stage.
package fetch_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned PC_INC = 4;
  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, addresses a 1-cycle-latency ROM, hands pairs to decode.
// Optional feature: FETCH_REDIRECT_BYPASS_EN sends a redirect target to the ROM in the same cycle.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 256,
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  localparam int unsigned AW = $clog2(MEM_DEPTH)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            redirect_valid_i,
  input  logic [31:0]     redirect_pc_i,
  output logic [AW+1:2]   imem_addr_o,
  input  logic [31:0]     imem_rdata_i,
  output logic            if_valid_o,
  input  logic            if_ready_i,
  output logic [31:0]     if_pc_o,
  output logic [31:0]     if_instr_o
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic            resp_valid_q, resp_valid_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;

  logic            stall_c;
  logic [XLEN-1:0] target_c;
  logic [XLEN-1:0] addr_pc_c;
  logic            unused_c;

  assign stall_c  = resp_valid_q & ~if_ready_i;
  assign target_c = {redirect_pc_i[XLEN-1:2], 2'b00};

  // ROM address: re-read the held word on a stall so its data stays put.
  always_comb begin
    addr_pc_c = pc_q;
`ifdef FETCH_REDIRECT_BYPASS_EN
    if (redirect_valid_i) begin
      addr_pc_c = target_c;
    end else if (stall_c) begin
      addr_pc_c = resp_pc_q;
    end
`else
    if (stall_c) begin
      addr_pc_c = resp_pc_q;
    end
`endif
  end

  assign imem_addr_o = addr_pc_c[AW+1:2];
  assign unused_c    = ^{addr_pc_c[XLEN-1:AW+2], addr_pc_c[1:0], redirect_pc_i[1:0]};

  always_comb begin
    pc_d         = pc_q;
    resp_valid_d = resp_valid_q;
    resp_pc_d    = resp_pc_q;
    if (redirect_valid_i) begin
`ifdef FETCH_REDIRECT_BYPASS_EN
      resp_pc_d    = target_c;
      resp_valid_d = 1'b1;
      pc_d         = target_c + XLEN'(PC_INC);
`else
      // Target is requested next cycle; the in-flight response is dropped.
      pc_d         = target_c;
      resp_valid_d = 1'b0;
`endif
    end else if (!stall_c) begin
      resp_pc_d    = pc_q;
      resp_valid_d = 1'b1;
      pc_d         = pc_q + XLEN'(PC_INC);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q         <= RESET_PC;
      resp_valid_q <= 1'b0;
      resp_pc_q    <= RESET_PC;
    end else begin
      pc_q         <= pc_d;
      resp_valid_q <= resp_valid_d;
      resp_pc_q    <= resp_pc_d;
    end
  end

  assign if_valid_o = resp_valid_q;
  assign if_pc_o    = resp_pc_q;
  assign if_instr_o = resp_valid_q ? imem_rdata_i : INSTR_NOP;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a behavioural 1-cycle ROM beside the DUT.
module tb_instr_fetch;

  localparam int unsigned MEM_DEPTH = 256;
  localparam int unsigned AW = $clog2(MEM_DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic          clk;
  logic          rst;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic [AW+1:2] imem_addr;
  logic [31:0]   imem_rdata;
  logic          if_valid;
  logic          if_ready;
  logic [31:0]   if_pc;
  logic [31:0]   if_instr;

  logic [31:0]   rom [MEM_DEPTH];

  int n_checks = 0;
  int n_errors = 0;

  instr_fetch #(
    .MEM_DEPTH (MEM_DEPTH),
    .RESET_PC  (32'h0000_0000)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .redirect_valid_i (redirect_valid),
    .redirect_pc_i    (redirect_pc),
    .imem_addr_o      (imem_addr),
    .imem_rdata_i     (imem_rdata),
    .if_valid_o       (if_valid),
    .if_ready_i       (if_ready),
    .if_pc_o          (if_pc),
    .if_instr_o       (if_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_ff @(posedge clk) imem_rdata <= rom[imem_addr];

  function automatic logic [31:0] rom_word(input logic [31:0] pc);
    return 32'hA000_0000 + {24'h0, pc[9:2]};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_pair(input string tag, input logic [31:0] pc);
    check({tag, ".valid"}, {31'h0, if_valid}, 32'h1);
    check({tag, ".pc"}, if_pc, pc);
    check({tag, ".instr"}, if_instr, rom_word(pc));
  endtask

  task automatic expect_idle(input string tag);
    check({tag, ".valid"}, {31'h0, if_valid}, 32'h0);
    check({tag, ".instr"}, if_instr, NOP);
  endtask

  // Redirect in the current cycle, then advance to the cycle the target shows up.
  task automatic redirect_to(input string tag, input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    tick();
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
`ifndef FETCH_REDIRECT_BYPASS_EN
    if_ready = 1'b1;
    expect_idle({tag, ".gap"});
    tick();
`endif
  endtask

  initial begin
    for (int i = 0; i < int'(MEM_DEPTH); i++) rom[i] = 32'hA000_0000 + 32'(i);
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    if_ready       = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Cycle 0: nothing valid yet, RESET_PC on the ROM address.
    expect_idle("reset");
    check("reset.addr", 32'(imem_addr), 32'h0);

    tick();
    expect_pair("c1", 32'h0);
    tick();
    expect_pair("c2", 32'h4);
    tick();

    // Backpressure on pc=0x8 for three cycles.
    for (int k = 0; k < 3; k++) begin
      if_ready = 1'b0;
      #1;
      expect_pair($sformatf("stall%0d", k), 32'h8);
      check($sformatf("stall%0d.addr", k), 32'(imem_addr), 32'h2);
      tick();
    end
    if_ready = 1'b1;
    expect_pair("release", 32'h8);
    tick();
    expect_pair("after_release", 32'hC);

    // Redirect on a firing cycle.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    #1;
`ifdef FETCH_REDIRECT_BYPASS_EN
    check("redir.addr", 32'(imem_addr), 32'h10);
`else
    check("redir.addr", 32'(imem_addr), 32'h4);
`endif
    redirect_to("redir40", 32'h40);
    expect_pair("redir40.tgt", 32'h40);
    tick();
    expect_pair("redir40.next", 32'h44);

    // Redirect while stalled on 0x48: the stalled pair must never fire.
    tick();
    if_ready = 1'b0;
    #1;
    expect_pair("stall48", 32'h48);
    redirect_to("redir20", 32'h20);
    if_ready = 1'b1;
    expect_pair("redir20.tgt", 32'h20);
    tick();
    expect_pair("redir20.next", 32'h24);

    // Wrap of the ROM address past the last word.
    tick();
    redirect_to("redir3fc", 32'h3FC);
    expect_pair("wrap.last", 32'h3FC);
    check("wrap.addr", 32'(imem_addr), 32'h0);
    tick();
    expect_pair("wrap.first", 32'h400);

    // Unaligned target is forced to a word boundary.
    redirect_to("redir13", 32'h13);
    expect_pair("align", 32'h10);

    // Reset mid-stream at pc=0x24.
    tick();
    redirect_to("redir20b", 32'h20);
    tick();
    expect_pair("pre_rst", 32'h24);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expect_idle("post_rst");
    tick();
    expect_pair("restart", 32'h0);
    tick();
    expect_pair("restart.next", 32'h4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
